// File: rtl/mult_controller.sv
// -----------------------------------------------------------------------------
// mult_controller
//
// Sequences the shared 32x32 multi-cycle multiplier for MULT/MULTU and owns the
// architectural HI/LO registers. Signed operands are reduced to magnitudes
// before they reach the multiplier, and the unsigned 64-bit product is negated
// afterwards when the operand signs differ.
//
// Ports:
//   Clk          clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   start        multiply request, accepted only while idle
//   is_signed    1 = MULT, 0 = MULTU (sampled with start)
//   lhs, rhs     operands (sampled with start)
//   rd_hi/rd_lo  MFHI/MFLO in decode (only affect stall)
//   wr_hi/wr_lo  MTHI/MTLO write strobes, data on wr_data
//   mul_work     work enable to the multiplier
//   mul_lhs/rhs  operand magnitudes to the multiplier, stable while busy
//   mul_result   unsigned product from the multiplier
//   mul_done     multiplier end flag, idles high
//   hi, lo       architectural HI/LO
//   busy         an operation is in flight
//   stall        busy and a HI/LO-related request is present
//   done         one-cycle pulse in the cycle HI/LO are being written
//   timeout_err  sticky abort flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module mult_controller #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic        rd_hi,
  input  logic        rd_lo,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic        mul_work,
  output logic [31:0] mul_lhs,
  output logic [31:0] mul_rhs,
  input  logic [63:0] mul_result,
  input  logic        mul_done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, FIX} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       hi_reg, lo_reg;
  logic [31:0]       mul_lhs_reg, mul_rhs_reg;
  logic [63:0]       product_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_inc;
  logic              neg_reg;
  logic              timeout_err_reg;

  logic              accept;
  logic              capture;
  logic              abort;
  logic              timeout_hit;

  // Operand magnitudes. For MULT a negative operand is two's-complement
  // negated; 0x80000000 negates to itself and is then read as unsigned 2^31.
  logic [1:0][31:0]  op_raw;
  logic [1:0][31:0]  op_mag;

  assign op_raw = {rhs, lhs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mag
      assign op_mag[gi] = (is_signed && op_raw[gi][31]) ? (~op_raw[gi] + 32'd1)
                                                        : op_raw[gi];
    end
  endgenerate

  assign cnt_inc     = cnt_reg + CNT_W'(1);
  // The cycle that would bring the counter to the limit is the last one
  // allowed in ARM/RUN; it aborts even if the multiplier finishes then.
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // State register
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    mul_work   = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept     = 1'b1;
          state_next = ARM;
        end
      end
      ARM: begin
        // mul_done idles high, so completion can only be recognised after
        // the multiplier has first pulled it low.
        mul_work = 1'b1;
        if (timeout_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (!mul_done) begin
          state_next = RUN;
        end
      end
      RUN: begin
        mul_work = 1'b1;
        if (timeout_hit) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (mul_done) begin
          capture    = 1'b1;
          state_next = FIX;
        end
      end
      FIX: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand latches, cycle counter, product and HI/LO
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      hi_reg          <= 32'd0;
      lo_reg          <= 32'd0;
      mul_lhs_reg     <= 32'd0;
      mul_rhs_reg     <= 32'd0;
      product_reg     <= 64'd0;
      cnt_reg         <= '0;
      neg_reg         <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (accept) begin
        mul_lhs_reg     <= op_mag[0];
        mul_rhs_reg     <= op_mag[1];
        neg_reg         <= is_signed & (lhs[31] ^ rhs[31]);
        cnt_reg         <= '0;
        timeout_err_reg <= 1'b0;
      end else if (state_reg == IDLE) begin
        // MTHI/MTLO only land when no multiply is being accepted
        if (wr_hi) hi_reg <= wr_data;
        if (wr_lo) lo_reg <= wr_data;
      end

      if (mul_work) cnt_reg <= cnt_inc;
      if (abort)    timeout_err_reg <= 1'b1;
      if (capture)  product_reg <= mul_result;

      if (state_reg == FIX) begin
        {hi_reg, lo_reg} <= neg_reg ? (~product_reg + 64'd1) : product_reg;
      end
    end
  end

  assign hi          = hi_reg;
  assign lo          = lo_reg;
  assign mul_lhs     = mul_lhs_reg;
  assign mul_rhs     = mul_rhs_reg;
  assign timeout_err = timeout_err_reg;
  assign stall       = busy & (start | rd_hi | rd_lo | wr_hi | wr_lo);

endmodule

// File: tb/tb_mult_controller.sv
// -----------------------------------------------------------------------------
// tb_mult_controller
//
// Self-checking bench for mult_controller. A simple multiplier model answers
// the work/done handshake with configurable latencies. A transaction-level
// reference model (signed/unsigned 64-bit products, HI/LO write rules, abort
// after 64 cycles in flight) predicts every output, and one compare process
// checks the DUT against it each cycle. Directed operations with literal
// results pin the model; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mult_controller;

  localparam int TIMEOUT = 64;

  logic        Clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic        rd_hi;
  logic        rd_lo;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        mul_work;
  logic [31:0] mul_lhs;
  logic [31:0] mul_rhs;
  logic [63:0] mul_result = 64'd0;
  logic        mul_done   = 1'b1;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mult_controller #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .Clk(Clk), .reset(reset), .start(start), .is_signed(is_signed),
    .lhs(lhs), .rhs(rhs), .rd_hi(rd_hi), .rd_lo(rd_lo),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .mul_work(mul_work), .mul_lhs(mul_lhs), .mul_rhs(mul_rhs),
    .mul_result(mul_result), .mul_done(mul_done),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done),
    .timeout_err(timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Multiplier model: done idles high, falls lat_drop cycles after work is
  // seen, rises with the product lat_run cycles later. While idle the result
  // bus carries garbage so a premature capture shows up as a wrong product.
  // ---------------------------------------------------------------------------
  bit stuck     = 1'b0;
  bit fixed_lat = 1'b1;
  int fix_drop  = 1;
  int fix_run   = 1;
  int m_phase   = 0;
  int m_cnt     = 0;
  int lat_drop  = 1;
  int lat_run   = 1;

  always @(posedge Clk) begin
    if (!mul_work) begin
      m_phase    <= 0;
      m_cnt      <= 0;
      mul_done   <= 1'b1;
      mul_result <= {$urandom, $urandom};
      lat_drop   <= fixed_lat ? fix_drop : int'($urandom_range(1, 3));
      lat_run    <= fixed_lat ? fix_run  : int'($urandom_range(1, 6));
    end else begin
      case (m_phase)
        0: if (!stuck) begin
          if (m_cnt + 1 >= lat_drop) begin
            mul_done <= 1'b0;
            m_phase  <= 1;
            m_cnt    <= 0;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        1: begin
          if (m_cnt + 1 >= lat_run) begin
            mul_done   <= 1'b1;
            mul_result <= {32'd0, mul_lhs} * {32'd0, mul_rhs};
            m_phase    <= 2;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_mag(input logic s, input logic [31:0] a);
    longint v;
    v = s ? longint'($signed(a)) : longint'({32'd0, a});
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  bit          m_busy, m_fix, m_low;
  int          m_n;
  logic [31:0] exp_hi, exp_lo, exp_mlhs, exp_mrhs;
  logic [63:0] exp_prod;
  logic        exp_terr;

  // An operation in flight: count cycles, remember whether done has been seen
  // low; done seen high afterwards completes it, and the following cycle
  // writes HI/LO. The 64th in-flight cycle aborts instead.
  always @(posedge Clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_fix <= 1'b0; m_low <= 1'b0; m_n <= 0;
      exp_hi <= 32'd0; exp_lo <= 32'd0; exp_mlhs <= 32'd0; exp_mrhs <= 32'd0;
      exp_prod <= 64'd0; exp_terr <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy   <= 1'b1;
        m_fix    <= 1'b0;
        m_low    <= 1'b0;
        m_n      <= 0;
        exp_terr <= 1'b0;
        exp_mlhs <= ref_mag(is_signed, lhs);
        exp_mrhs <= ref_mag(is_signed, rhs);
        exp_prod <= ref_prod(is_signed, lhs, rhs);
      end else begin
        if (wr_hi) exp_hi <= wr_data;
        if (wr_lo) exp_lo <= wr_data;
      end
    end else if (m_fix) begin
      exp_hi <= exp_prod[63:32];
      exp_lo <= exp_prod[31:0];
      m_busy <= 1'b0;
      m_fix  <= 1'b0;
    end else if (m_n + 1 >= TIMEOUT) begin
      m_busy   <= 1'b0;
      exp_terr <= 1'b1;
    end else begin
      m_n <= m_n + 1;
      if (m_low && mul_done) m_fix <= 1'b1;
      else if (!mul_done)    m_low <= 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge Clk);
      #2;
      if (reset && chk_en) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_busy && m_fix);
        chk("mul_work", mul_work, m_busy && !m_fix);
        chk("stall", stall, m_busy && (start || rd_hi || rd_lo || wr_hi || wr_lo));
        chk("hi", hi, exp_hi);
        chk("lo", lo, exp_lo);
        chk("mul_lhs", mul_lhs, exp_mlhs);
        chk("mul_rhs", mul_rhs, exp_mrhs);
        chk("timeout_err", timeout_err, exp_terr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    start = 1'b0; rd_hi = 1'b0; rd_lo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int d0, input int d1,
                        output int busy_cycles, output int pulses);
    fixed_lat = 1'b1; fix_drop = d0; fix_run = d1;
    @(negedge Clk);
    start = 1'b1; is_signed = s; lhs = a; rhs = b;
    @(negedge Clk);
    start = 1'b0;
    busy_cycles = 0;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      #2;
      if (!busy) break;
      busy_cycles++;
      if (done) pulses++;
      @(negedge Clk);
    end
    chk("op_finished", busy, 1'b0);
    $display("op s=%0d %08h x %08h -> hi=%08h lo=%08h busy_cycles=%0d done_pulses=%0d terr=%0d",
             s, a, b, hi, lo, busy_cycles, pulses, timeout_err);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      #2;
      if (!busy) break;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int bc, dp;

  initial begin
    reset = 1'b0;
    idle_inputs();
    is_signed = 1'b0; lhs = 32'd0; rhs = 32'd0; wr_data = 32'd0;
    start = 1'b1;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mul_work", mul_work, 1'b0);
    chk("rst_mul_lhs", mul_lhs, 32'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    start = 1'b0;
    repeat (2) @(negedge Clk);
    reset = 1'b1;
    chk_en = 1'b1;

    // MULTU 3 x 5 with done low one cycle after work, high four cycles later
    run_op(1'b0, 32'd3, 32'd5, 1, 4, bc, dp);
    chk("multu_3x5_hi", hi, 32'd0);
    chk("multu_3x5_lo", lo, 32'd15);
    chk("multu_3x5_latency", 64'(bc), 64'd7);
    chk("multu_3x5_pulses", 64'(dp), 64'd1);

    // MULT -2 x 7
    run_op(1'b1, 32'hFFFF_FFFE, 32'd7, 2, 3, bc, dp);
    chk("mult_m2x7_mlhs", mul_lhs, 32'd2);
    chk("mult_m2x7_mrhs", mul_rhs, 32'd7);
    chk("mult_m2x7_hi", hi, 32'hFFFF_FFFF);
    chk("mult_m2x7_lo", lo, 32'hFFFF_FFF2);

    // MULT most-negative squared
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1, 1, bc, dp);
    chk("mult_min_mlhs", mul_lhs, 32'h8000_0000);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'd0);

    // MULTU all-ones squared
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 6, bc, dp);
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    // Multiplier never leaves idle-high: abort after 64 cycles
    stuck = 1'b1;
    run_op(1'b0, 32'd11, 32'd13, 1, 1, bc, dp);
    chk("timeout_cycles", 64'(bc), 64'd64);
    chk("timeout_pulses", 64'(dp), 64'd0);
    chk("timeout_flag", timeout_err, 1'b1);
    chk("timeout_hi", hi, 32'hFFFF_FFFE);
    chk("timeout_lo", lo, 32'h0000_0001);
    stuck = 1'b0;

    // Requests during RUN stall and the second start is never taken
    fix_drop = 1; fix_run = 8;
    @(negedge Clk);
    start = 1'b1; is_signed = 1'b0; lhs = 32'd7; rhs = 32'd9;
    @(negedge Clk);
    start = 1'b0;
    #2;
    chk("terr_cleared", timeout_err, 1'b0);
    chk("accept_busy", busy, 1'b1);
    repeat (3) @(negedge Clk);
    start = 1'b1; rd_lo = 1'b1; lhs = 32'h11; rhs = 32'h22;
    repeat (3) begin
      #2;
      chk("stall_run", stall, 1'b1);
      $display("stall cycle: busy=%0d stall=%0d", busy, stall);
      @(negedge Clk);
    end
    idle_inputs();
    wait_idle();
    chk("stall_op_hi", hi, 32'd0);
    chk("stall_op_lo", lo, 32'd63);
    repeat (3) begin
      @(negedge Clk);
      #2;
      chk("no_second_op", busy, 1'b0);
    end

    // start beats wr_hi in the same idle cycle
    @(negedge Clk);
    start = 1'b1; wr_hi = 1'b1; wr_data = 32'hCAFE_0000;
    is_signed = 1'b0; lhs = 32'h0001_0000; rhs = 32'h0001_0000;
    @(negedge Clk);
    idle_inputs();
    #2;
    chk("start_beats_wr_hi", hi, 32'd0);
    wait_idle();
    chk("op_2p32_hi", hi, 32'd1);
    chk("op_2p32_lo", lo, 32'd0);

    // MTHI and MTLO together while idle
    @(negedge Clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0000_A5A5;
    @(negedge Clk);
    idle_inputs();
    #2;
    chk("mthi_mtlo_hi", hi, 32'h0000_A5A5);
    chk("mthi_mtlo_lo", lo, 32'h0000_A5A5);

    // Asynchronous reset in the middle of RUN
    fix_drop = 1; fix_run = 20;
    @(negedge Clk);
    start = 1'b1; is_signed = 1'b0; lhs = 32'h1234; rhs = 32'h10;
    @(negedge Clk);
    start = 1'b0;
    repeat (4) @(negedge Clk);
    rd_lo = 1'b1;
    @(posedge Clk);
    #3;
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_mul_work", mul_work, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_stall", stall, 1'b0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_done", done, 1'b0);
    $display("async reset: busy=%0d mul_work=%0d hi=%08h lo=%08h", busy, mul_work, hi, lo);
    repeat (2) begin
      @(negedge Clk);
      #2;
      chk("arst_hold_done", done, 1'b0);
    end
    @(negedge Clk);
    idle_inputs();
    reset = 1'b1;

    // Randomized traffic against the reference model
    fixed_lat = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge Clk);
      start     = ($urandom_range(0, 5) == 0);
      is_signed = 1'($urandom_range(0, 1));
      lhs       = pick_operand();
      rhs       = pick_operand();
      rd_hi     = ($urandom_range(0, 3) == 0);
      rd_lo     = ($urandom_range(0, 3) == 0);
      wr_hi     = ($urandom_range(0, 7) == 0);
      wr_lo     = ($urandom_range(0, 7) == 0);
      wr_data   = $urandom;
      if (done) $display("random op complete: hi=%08h lo=%08h", hi, lo);
    end
    @(negedge Clk);
    idle_inputs();
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_controller.md
Name: mult_controller

Overview:
- Sequences the shared 32x32 multi-cycle multiplier for the MIPS core's MULT/MULTU instructions and owns the architectural HI/LO registers.
- Converts signed operands to magnitudes, drives the multiplier's work/done handshake and sign-corrects the 64-bit product.
- Writes HI/LO and stalls the pipeline on MFHI/MFLO/MTHI/MTLO or a new MULT while an operation is in flight.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in ARM+RUN combined before the operation is aborted.
- CNT_W, 7, width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately when low.
- start  in  1  request a multiply; accepted only in IDLE.
- is_signed  in  1  1 = MULT, 0 = MULTU; sampled with start.
- lhs, rhs  in  32 each  operands; sampled with start.
- rd_hi, rd_lo  in  1 each  MFHI/MFLO in decode.
- wr_hi, wr_lo  in  1 each  MTHI/MTLO write strobes.
- wr_data  in  32  data for MTHI/MTLO.
- mul_work  out  1  work enable to the multiplier.
- mul_lhs, mul_rhs  out  32 each  operand magnitudes to the multiplier.
- mul_result  in  64  unsigned product from the multiplier.
- mul_done  in  1  multiplier end signal; idles high.
- hi, lo  out  32 each  architectural HI/LO.
- busy  out  1  high whenever state != IDLE.
- stall  out  1  busy & (start|rd_hi|rd_lo|wr_hi|wr_lo).
- done  out  1  one-cycle pulse when HI/LO are updated by a multiply.
- timeout_err  out  1  sticky; set on abort, cleared on the next accepted start.

Behaviour:
- Reset (reset low, async): state=IDLE, hi=lo=0, mul_work=0, mul_lhs=mul_rhs=0, counter=0, neg=0, done=0, timeout_err=0, busy=0, stall=0.
- Reset mid-operation aborts immediately. HI/LO go to 0. No done pulse is issued.
- States: IDLE, ARM, RUN, FIX.
- IDLE:
  - On start: latch mul_lhs=|lhs| and mul_rhs=|rhs| when is_signed, else the raw values. Latch neg = is_signed & (lhs[31]^rhs[31]). Clear counter and timeout_err. Go to ARM.
  - |0x80000000| is 0x80000000, treated as unsigned.
  - start has priority over wr_hi/wr_lo in the same cycle; those writes are dropped.
  - Without start: wr_hi loads hi and wr_lo loads lo from wr_data. Both strobes together load both.
- ARM:
  - mul_work=1, counter increments each cycle.
  - Wait for mul_done=0 (the multiplier has left its idle-high state), then go to RUN.
  - A mul_done that was already high is never taken as completion.
- RUN:
  - mul_work=1, counter increments.
  - On mul_done=1: latch product=mul_result and go to FIX.
- Timeout: if counter reaches TIMEOUT_CYCLES in ARM or RUN, set timeout_err, drop mul_work, and return to IDLE. HI/LO are unchanged and no done pulse is issued.
- FIX (1 cycle):
  - mul_work=0.
  - hi/lo = neg ? (~product+1) split [63:32]/[31:0] : product split the same way. Arithmetic is modulo 2^64.
  - done=1 for this cycle, then IDLE.
- Latency (start to HI/LO visible): start cycle + ARM cycles + RUN cycles + 1 (FIX). Minimum 3 cycles after the start edge.
- rd_hi/rd_lo in IDLE: no stall; hi/lo hold valid values. In FIX, stall is still high; the values are readable the next cycle.
- start while busy: ignored, stall=1. The requester must hold start until stall drops.
- mul_lhs/mul_rhs are held stable from acceptance until IDLE.

Test Plan:
- MULTU 0x0000_0003 x 0x0000_0005, model done goes low 1 cycle after work and high 4 cycles later -> hi=0, lo=15, done pulses once, busy drops the same cycle.
- MULT 0xFFFF_FFFE (-2) x 0x0000_0007 -> mul_lhs=2, mul_rhs=7, hi=0xFFFF_FFFF, lo=0xFFFF_FFF2.
- MULT 0x8000_0000 x 0x8000_0000 -> hi=0x4000_0000, lo=0; MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- Model holds mul_done high forever -> no completion, timeout_err=1 after 64 cycles, hi/lo unchanged, next start clears timeout_err.
- rd_lo and start asserted during RUN -> stall=1 until IDLE, the second start is not accepted; wr_hi=1 with start in IDLE -> hi unchanged.
- reset driven low mid-RUN (asynchronous to Clk) -> mul_work=0, hi=lo=0 and busy=0 immediately, with no done pulse.
